// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between an ALU client and alu_seq
interface alu_seq_if #(parameter int WIDTH = 8) ();
  logic             start;
  logic [3:0]       opsel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] f;
  logic             carry;
  logic             zero;
  logic             err;
  logic             busy;
  logic             done;
  modport master (output start, opsel, a, b, input f, carry, zero, err, busy, done);
  modport slave  (input start, opsel, a, b, output f, carry, zero, err, busy, done);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and a WIDTH-cycle shift-add multiplier
module alu_seq #(parameter int WIDTH = 8) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, mcand, acc_n;
  logic [WIDTH-1:0]   mplier, f_q, res_f;
  logic [CW-1:0]      cnt;
  logic               carry_q, zero_q, err_q, done_q, res_c, res_e, accept, last, fin;
  assign accept = state == IDLE && bus.start;
  assign last   = state == MUL && cnt == CW'(WIDTH - 1);
  assign acc_n  = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = accept && bus.opsel == 4'd10 ? MUL : IDLE;
    else               state_n = last ? IDLE : MUL;
  end
  always_comb begin
    res_f = '0;
    res_c = 1'b0;
    res_e = 1'b0;
    fin   = last || (accept && bus.opsel != 4'd10);
    if (state == MUL) begin
      res_f = acc_n[WIDTH-1:0];
      res_c = |acc_n[2*WIDTH-1:WIDTH];
    end else
      case (bus.opsel)
        4'd0: {res_c, res_f} = {1'b0, bus.a} + {1'b0, bus.b};
        4'd1: {res_c, res_f} = {1'b0, bus.a} + (WIDTH+1)'(1);
        4'd2: {res_c, res_f} = {1'b0, bus.b} + (WIDTH+1)'(1);
        4'd3: res_f = bus.a & bus.b;
        4'd4: res_f = bus.a | bus.b;
        4'd5: res_f = ~bus.a;
        4'd6: {res_c, res_f} = {bus.a, 1'b0};
        4'd7: {res_f, res_c} = {1'b0, bus.a};
        4'd8: res_f = bus.a;
        4'd9: res_f = bus.b;
        4'd10: res_f = '0;
        default: res_e = 1'b1;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      f_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        f_q     <= res_f;
        carry_q <= res_c;
        zero_q  <= res_f == '0;
        err_q   <= res_e;
      end
      if (accept && bus.opsel == 4'd10) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, bus.a};
        mplier <= bus.b;
        cnt    <= '0;
      end else if (state == MUL) begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  assign bus.f     = f_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.err   = err_q;
  assign bus.done  = done_q;
  assign bus.busy  = state == MUL;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=8
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic seen_done;
  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic s, input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    bus.start = s;
    bus.opsel = op;
    bus.a     = av;
    bus.b     = bv;
  endtask
  initial begin
    rst = 1'b1;
    drive(1'b1, 4'd9, 8'hAA, 8'hAA);
    tick();
    tick();
    check("rst_f", {24'b0, bus.f}, 32'h00);
    check("rst_carry", {31'b0, bus.carry}, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 4'd0, 8'hFF, 8'h01);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    check("add_f", {24'b0, bus.f}, 32'h00);
    check("add_carry", {31'b0, bus.carry}, 32'd1);
    check("add_zero", {31'b0, bus.zero}, 32'd1);
    check("add_done", {31'b0, bus.done}, 32'd1);
    check("add_busy", {31'b0, bus.busy}, 32'd0);
    check("add_err", {31'b0, bus.err}, 32'd0);
    tick();
    check("add_done_low", {31'b0, bus.done}, 32'd0);
    check("add_hold_carry", {31'b0, bus.carry}, 32'd1);
    drive(1'b1, 4'd6, 8'h81, 8'h00);
    tick();
    check("shl_f", {24'b0, bus.f}, 32'h02);
    check("shl_carry", {31'b0, bus.carry}, 32'd1);
    check("shl_done", {31'b0, bus.done}, 32'd1);
    drive(1'b1, 4'd7, 8'h81, 8'h00);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    check("shr_f", {24'b0, bus.f}, 32'h40);
    check("shr_carry", {31'b0, bus.carry}, 32'd1);
    check("shr_done", {31'b0, bus.done}, 32'd1);
    tick();
    check("shr_done_low", {31'b0, bus.done}, 32'd0);
    drive(1'b1, 4'd10, 8'h12, 8'h0F);
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul_busy%0d", i), {31'b0, bus.busy}, 32'd1);
      check($sformatf("mul_nodone%0d", i), {31'b0, bus.done}, 32'd0);
      drive(i == 3, 4'd0, 8'h01, 8'h01);
      tick();
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    check("mul_f", {24'b0, bus.f}, 32'h0E);
    check("mul_carry", {31'b0, bus.carry}, 32'd1);
    check("mul_zero", {31'b0, bus.zero}, 32'd0);
    check("mul_done", {31'b0, bus.done}, 32'd1);
    check("mul_idle", {31'b0, bus.busy}, 32'd0);
    tick();
    check("mul_no_extra_done", {31'b0, bus.done}, 32'd0);
    check("mul_hold_f", {24'b0, bus.f}, 32'h0E);
    drive(1'b1, 4'd10, 8'h10, 8'h0F);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    repeat (7) tick();
    check("mul2_busy_last", {31'b0, bus.busy}, 32'd1);
    tick();
    check("mul2_f", {24'b0, bus.f}, 32'hF0);
    check("mul2_carry", {31'b0, bus.carry}, 32'd0);
    check("mul2_zero", {31'b0, bus.zero}, 32'd0);
    check("mul2_done", {31'b0, bus.done}, 32'd1);
    drive(1'b1, 4'd12, 8'h33, 8'h44);
    tick();
    check("bad_f", {24'b0, bus.f}, 32'h00);
    check("bad_err", {31'b0, bus.err}, 32'd1);
    check("bad_zero", {31'b0, bus.zero}, 32'd1);
    check("bad_carry", {31'b0, bus.carry}, 32'd0);
    check("bad_done", {31'b0, bus.done}, 32'd1);
    drive(1'b1, 4'd9, 8'h00, 8'h5A);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    check("passb_f", {24'b0, bus.f}, 32'h5A);
    check("passb_err", {31'b0, bus.err}, 32'd0);
    check("passb_done", {31'b0, bus.done}, 32'd1);
    drive(1'b1, 4'd10, 8'h12, 8'h0F);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    repeat (3) tick();
    check("abort_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_f", {24'b0, bus.f}, 32'h00);
    check("abort_carry", {31'b0, bus.carry}, 32'd0);
    check("abort_zero", {31'b0, bus.zero}, 32'd0);
    check("abort_err", {31'b0, bus.err}, 32'd0);
    check("abort_busy_low", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    seen_done = 1'b0;
    repeat (10) begin
      tick();
      seen_done = seen_done | bus.done;
    end
    check("abort_no_done", {31'b0, seen_done}, 32'd0);
    drive(1'b1, 4'd1, 8'h7F, 8'h00);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    check("inca_f", {24'b0, bus.f}, 32'h80);
    check("inca_carry", {31'b0, bus.carry}, 32'd0);
    check("inca_done", {31'b0, bus.done}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
